// File: rtl/cavlc_pkg.sv
// Shared state encoding and constants for the CAVLC level decoding stage.
package cavlc_pkg;

  localparam int LEVEL_W         = 16;
  localparam int MAX_SUFFIX_LEN  = 6;
  localparam int PREFIX_ESC      = 15;
  localparam int PREFIX14_SUFFIX = 4;
  localparam int ESC_SUFFIX      = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_T1S   = 2'd1,
    ST_LEVEL = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/cavlc_lzc16.sv
// 16-bit leading-zero counter; count is 16 and zero_o is set when no bit is set.
module cavlc_lzc16 (
  input  logic [15:0] data_i,
  output logic [4:0]  count_o,
  output logic        zero_o
);

  // Scanning upward lets the highest set bit overwrite lower ones.
  always_comb begin
    count_o = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (data_i[i]) count_o = 5'(15 - i);
    end
  end

  assign zero_o = (data_i == 16'd0);

endmodule

// File: rtl/cavlc_level_decoder.sv
// CAVLC level decoder: parses trailing-one signs and level_prefix/level_suffix
// codes from an MSB-first bit window, one signed level per cycle.
// Handshake: bit_shift_en_o is combinational; when high, upstream advances its
// window by bit_shift_o bits at the next clock edge. It only rises with bit_valid_i.
module cavlc_level_decoder
  import cavlc_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [4:0]         total_coeff_i,
  input  logic [1:0]         trailing_ones_i,
  input  logic [31:0]        bit_win_i,
  input  logic               bit_valid_i,
  output logic               bit_shift_en_o,
  output logic [5:0]         bit_shift_o,
  output logic               level_valid_o,
  output logic [3:0]         level_idx_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output state_e             state_o
);

  state_e             state_q, state_d;
  logic [4:0]         tc_q, tc_d;
  logic [1:0]         t1_q, t1_d;
  logic [3:0]         sl_q, sl_d;
  logic [4:0]         idx_q, idx_d;
  logic               level_valid_q, level_valid_d;
  logic [3:0]         level_idx_q, level_idx_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic [4:0]         prefix;
  logic               prefix_none;
  logic [3:0]         suffix_size;
  logic [11:0]        suffix_win;
  logic [11:0]        suffix;
  logic [15:0]        level_code;
  logic [15:0]        level_mag;
  logic [LEVEL_W-1:0] level_signed;
  logic [3:0]         sl_base;
  logic [15:0]        sl_thresh;
  logic [3:0]         sl_next;
  logic [4:0]         idx_inc;

  cavlc_lzc16 u_lzc (
    .data_i  (bit_win_i[31:16]),
    .count_o (prefix),
    .zero_o  (prefix_none)
  );

  always_comb begin
    if (prefix == 5'(PREFIX_ESC)) begin
      suffix_size = 4'(ESC_SUFFIX);
    end else if (prefix == 5'(PREFIX_ESC - 1) && sl_q == 4'd0) begin
      suffix_size = 4'(PREFIX14_SUFFIX);
    end else begin
      suffix_size = sl_q;
    end
  end

  // Window bit 30-prefix is the first suffix bit; zero padding covers the tail.
  assign suffix_win = 12'({bit_win_i, 12'd0} >> (6'd31 - 6'(prefix)));
  assign suffix     = suffix_win >> (4'(ESC_SUFFIX) - suffix_size);

  always_comb begin
    level_code = (16'(prefix) << sl_q) + 16'(suffix);
    if (prefix == 5'(PREFIX_ESC) && sl_q == 4'd0) level_code = level_code + 16'd15;
    if (idx_q == 5'(t1_q) && t1_q != 2'd3) level_code = level_code + 16'd2;
  end

  // Even codes are positive, odd codes negative; both magnitudes equal (code+2)>>1.
  assign level_mag    = (level_code + 16'd2) >> 1;
  assign level_signed = level_code[0] ? LEVEL_W'(0) - LEVEL_W'(level_mag) : LEVEL_W'(level_mag);

  assign sl_base   = (sl_q == 4'd0) ? 4'd1 : sl_q;
  assign sl_thresh = 16'd3 << (sl_base - 4'd1);
  assign sl_next   = (level_mag > sl_thresh && sl_base < 4'(MAX_SUFFIX_LEN)) ?
                     sl_base + 4'd1 : sl_base;
  assign idx_inc   = idx_q + 5'd1;

  always_comb begin
    state_d        = state_q;
    tc_d           = tc_q;
    t1_d           = t1_q;
    sl_d           = sl_q;
    idx_d          = idx_q;
    level_valid_d  = 1'b0;
    level_idx_d    = level_idx_q;
    level_d        = level_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    bit_shift_en_o = 1'b0;
    bit_shift_o    = 6'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          tc_d  = total_coeff_i;
          t1_d  = trailing_ones_i;
          sl_d  = (total_coeff_i > 5'd10 && trailing_ones_i != 2'd3) ? 4'd1 : 4'd0;
          idx_d = 5'd0;
          if (total_coeff_i == 5'd0)        state_d = ST_FIN;
          else if (trailing_ones_i != 2'd0) state_d = ST_T1S;
          else                              state_d = ST_LEVEL;
        end
      end
      ST_T1S: begin
        if (bit_valid_i) begin
          bit_shift_en_o = 1'b1;
          bit_shift_o    = 6'd1;
          level_valid_d  = 1'b1;
          level_idx_d    = idx_q[3:0];
          level_d        = bit_win_i[31] ? '1 : LEVEL_W'(1);
          idx_d          = idx_inc;
          if (idx_inc == 5'(t1_q)) state_d = (idx_inc == tc_q) ? ST_FIN : ST_LEVEL;
        end
      end
      ST_LEVEL: begin
        if (bit_valid_i) begin
          if (prefix_none) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_shift_en_o = 1'b1;
            bit_shift_o    = 6'(prefix) + 6'd1 + 6'(suffix_size);
            level_valid_d  = 1'b1;
            level_idx_d    = idx_q[3:0];
            level_d        = level_signed;
            sl_d           = sl_next;
            idx_d          = idx_inc;
            if (idx_inc == tc_q) state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      tc_q          <= 5'd0;
      t1_q          <= 2'd0;
      sl_q          <= 4'd0;
      idx_q         <= 5'd0;
      level_valid_q <= 1'b0;
      level_idx_q   <= 4'd0;
      level_q       <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tc_q          <= tc_d;
      t1_q          <= t1_d;
      sl_q          <= sl_d;
      idx_q         <= idx_d;
      level_valid_q <= level_valid_d;
      level_idx_q   <= level_idx_d;
      level_q       <= level_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign level_valid_o = level_valid_q;
  assign level_idx_o   = level_idx_q;
  assign level_o       = level_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign state_o       = state_q;

endmodule
